// File: rtl/wrap_mon_pkg.sv
// Shared types for the wrap event monitor: FSM states, event record, width defaults.
// The ERR state only exists when WRAP_MON_CHECK_EN is defined.
package wrap_mon_pkg;
    localparam int CW_DEF        = 10;
    localparam int GW_DEF        = 16;
    localparam int SEQ_W         = 8;
    localparam int DEFAULT_LIMIT = 500;

`ifdef WRAP_MON_CHECK_EN
    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    typedef struct packed {
        logic [SEQ_W-1:0]  seq;
        logic [GW_DEF-1:0] gap;
    } evt_t;

    function automatic logic [GW_DEF-1:0] sat_inc(input logic [GW_DEF-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/wrap_event_monitor_if.sv
// Wrap event stream: show-ahead head of the event FIFO with valid/ready handshake.
// master = monitor (drives head), slave = consumer (drives ready).
interface wrap_event_monitor_if #(
    parameter int GW = wrap_mon_pkg::GW_DEF
);
    logic                          evt_valid;
    logic                          evt_ready;
    logic [wrap_mon_pkg::SEQ_W-1:0] evt_seq;
    logic [GW-1:0]                 evt_gap;

    modport master (output evt_valid, output evt_seq, output evt_gap, input evt_ready);
    modport slave  (input evt_valid, input evt_seq, input evt_gap, output evt_ready);
endinterface

// File: rtl/wrap_evt_fifo.sv
// Show-ahead synchronous FIFO; push visible one edge later, head is zero when empty.
// Push while full is accepted only if a pop happens on the same edge, otherwise ignored.
module wrap_evt_fifo
    import wrap_mon_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = evt_t,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  T            i_push_dat,
    input  logic        i_pop,
    output T            o_head,
    output logic        o_full,
    output logic        o_empty,
    output logic [AW:0] o_level
);
    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_level   = r_level;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
        end
    end
endmodule

// File: rtl/wrap_event_monitor.sv
// Detects counter wraps, measures inter-wrap gaps, queues {seq,gap} events; event visible one edge after the wrap.
// Consumer backpressures via evt_ready; full FIFO without pop drops the event (sticky overflow). WRAP_MON_CHECK_EN adds a shadow checker.
module wrap_event_monitor
    import wrap_mon_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = CW_DEF,
    parameter int GW    = GW_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_step,
    input  logic [CW-1:0]            i_cnt,
    input  logic [CW-1:0]            i_limit,
    wrap_event_monitor_if.master     evt,
    output logic [GW-1:0]            o_wrap_count,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    output logic                     o_err
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [GW-1:0]    r_gap;
    logic [GW-1:0]    r_wrap_count;
    logic [SEQ_W-1:0] r_seq;
    logic             r_overflow;
    logic             w_wrap;
    logic             w_gap_cnt;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    evt_t             w_push_dat;
    evt_t             w_head;

`ifdef WRAP_MON_CHECK_EN
    logic [CW-1:0] r_shadow;
    logic          w_chk_fail;

    // Independent model of the upstream counter, compared against its pre-edge value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shadow <= '0;
        end else if (i_step) begin
            r_shadow <= (r_shadow == i_limit) ? {{(CW-1){1'b0}}, 1'b1} : r_shadow + 1'b1;
        end
    end

    assign w_chk_fail = (i_cnt != r_shadow) || (i_cnt > i_limit);
    assign o_err      = (r_state == ERR);
`else
    assign o_err      = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_wrap      = 1'b0;
        w_gap_cnt   = 1'b0;
        unique case (r_state)
            IDLE, RUN: begin
                w_wrap    = i_step && (i_cnt == i_limit);
                // The first step already counts toward the first gap.
                w_gap_cnt = (r_state == RUN) || i_step;
                if (r_state == IDLE && i_step) w_state_nxt = RUN;
`ifdef WRAP_MON_CHECK_EN
                if (w_chk_fail) begin
                    w_wrap      = 1'b0;
                    w_state_nxt = ERR;
                end
`endif
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_gap        <= '0;
            r_seq        <= '0;
            r_wrap_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wrap) begin
                r_gap        <= '0;
                r_seq        <= r_seq + 1'b1;
                r_wrap_count <= sat_inc(r_wrap_count);
            end else if (w_gap_cnt) begin
                r_gap <= sat_inc(r_gap);
            end
            if (w_wrap && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    always_comb begin
        w_push_dat     = '0;
        w_push_dat.seq = r_seq;
        w_push_dat.gap = sat_inc(r_gap);
    end

    assign w_pop = !w_empty && evt.evt_ready;

    wrap_evt_fifo #(
        .DEPTH (DEPTH),
        .T     (evt_t)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (w_wrap),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (o_level)
    );

    assign evt.evt_valid = !w_empty;
    assign evt.evt_seq   = w_head.seq;
    assign evt.evt_gap   = w_head.gap;
    assign o_wrap_count  = r_wrap_count;
    assign o_overflow    = r_overflow;
endmodule

// File: tb/tb_wrap_event_monitor.sv
// Randomised and directed stimulus against a cycle-indexed reference model; events scored through a queue.
module tb_wrap_event_monitor;
    import wrap_mon_pkg::*;

`ifdef WRAP_MON_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int DEPTH = 4;
    localparam int GMAX  = 65535;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_step = 1'b0;
    logic [9:0]  i_cnt = '0;
    logic [9:0]  i_limit = '0;
    logic [15:0] o_wrap_count;
    logic [2:0]  o_level;
    logic        o_overflow;
    logic        o_err;

    wrap_event_monitor_if #(.GW(16)) evt_if ();

    wrap_event_monitor #(.DEPTH(DEPTH), .CW(10), .GW(16)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_step       (i_step),
        .i_cnt        (i_cnt),
        .i_limit      (i_limit),
        .evt          (evt_if),
        .o_wrap_count (o_wrap_count),
        .o_level      (o_level),
        .o_overflow   (o_overflow),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int seq;
        int gap;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model state: values after the most recent edge.
    int m_st = 0, m_lvl = 0, m_seq = 0, m_wc = 0, m_shadow = 0;
    int m_ref = 0, m_edge = 0, cnt_ref = 0, m_limit = 4;
    bit m_ovf = 0, m_init = 0, m_after_rst = 0;

    // Snapshot compared by the monitor during the current cycle.
    bit s_chk = 0, s_ovf = 0, s_err = 0, s_after_rst = 0;
    int s_lvl = 0, s_wc = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply inputs for the next edge, advance the model across it, then wait for it.
    task automatic tick(input bit rst, input bit step, input bit rdy, input bit frc, input int fval);
        int cnt_in;
        int gap;
        bit fail, wrap, pop;
        cnt_in = frc ? fval : cnt_ref;
        i_rst  = rst;
        i_step = step;
        i_cnt  = 10'(cnt_in);
        i_limit = 10'(m_limit);
        evt_if.evt_ready = rdy;

        s_chk = m_init; s_lvl = m_lvl; s_ovf = m_ovf; s_wc = m_wc;
        s_err = (m_st == 2); s_after_rst = m_after_rst;

        if (rst) begin
            m_st = 0; m_lvl = 0; m_seq = 0; m_wc = 0; m_ovf = 0;
            m_shadow = 0; cnt_ref = 0; sbq.delete();
            m_init = 1; m_after_rst = 1;
        end else begin
            m_after_rst = 0;
            fail = CHK && ((cnt_in != m_shadow) || (cnt_in > m_limit));
            wrap = step && (cnt_in == m_limit) && (m_st != 2) && !fail;
            pop  = (m_lvl != 0) && rdy;
            if (m_st == 0 && step) m_ref = m_edge - 1;
            if (wrap) begin
                gap = m_edge - m_ref;
                if (gap > GMAX) gap = GMAX;
                m_ref = m_edge;
                if (m_lvl < DEPTH || pop) begin
                    sbq.push_back('{seq: m_seq, gap: gap});
                    m_lvl++;
                end else begin
                    m_ovf = 1;
                end
                m_seq = (m_seq + 1) % 256;
                if (m_wc < GMAX) m_wc++;
            end
            if (pop) m_lvl--;
            if (fail) m_st = 2;
            else if (m_st == 0 && step) m_st = 1;
            if (step) begin
                m_shadow = (m_shadow == m_limit) ? 1 : m_shadow + 1;
                cnt_ref  = (cnt_ref == m_limit) ? 1 : cnt_ref + 1;
            end
        end
        m_edge++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lim);
        m_limit = lim;
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (s_chk) begin
            chk("level", o_level, s_lvl);
            chk("evt_valid", evt_if.evt_valid, s_lvl != 0);
            chk("overflow", o_overflow, s_ovf);
            chk("wrap_count", o_wrap_count, s_wc);
            chk("err", o_err, s_err);
            if (s_after_rst) begin
                chk("rst_evt_seq", evt_if.evt_seq, 0);
                chk("rst_evt_gap", evt_if.evt_gap, 0);
            end
            if (!i_rst && evt_if.evt_valid && evt_if.evt_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_evt", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("evt_seq", evt_if.evt_seq, e.seq);
                    chk("evt_gap", evt_if.evt_gap, e.gap);
                end
            end
        end
    end

    initial begin
        bit tg;
        evt_if.evt_ready = 1'b0;

        // Continuous stepping, consumer always ready.
        do_reset(4);
        repeat (40) tick(0, 1, 1, 0, 0);

        // Toggling step, no consumer: fill, overflow, then drain across the seq hole.
        do_reset(4);
        tg = 0;
        for (int c = 0; c < 200 && m_wc < 5; c++) begin
            tg = ~tg;
            tick(0, tg, 0, 0, 0);
        end
        repeat (3) tick(0, 0, 0, 0, 0);
        for (int c = 0; c < 40; c++) begin
            tg = ~tg;
            tick(0, tg, 1, 0, 0);
        end

        // Full FIFO with a wrap and a pop on the same edge.
        do_reset(4);
        for (int c = 0; c < 100 && m_lvl < DEPTH; c++) tick(0, 1, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            if (cnt_ref == m_limit) begin
                tick(0, 1, 1, 0, 0);
                break;
            end
            tick(0, 1, 0, 0, 0);
        end
        repeat (3) tick(0, 0, 0, 0, 0);
        repeat (8) tick(0, 0, 1, 0, 0);

        // Degenerate limit of zero: wrap on the very first step.
        do_reset(0);
        repeat (6) tick(0, 1, 1, 0, 0);

        // Random step/ready mixes over several limits.
        for (int r = 0; r < 4; r++) begin
            int sd, rd;
            do_reset($urandom_range(1, 6));
            sd = $urandom_range(1, 3);
            rd = $urandom_range(0, 3);
            repeat (300) tick(0, $urandom_range(0, 3) < sd, $urandom_range(0, 3) >= rd, 0, 0);
        end

        // Counter value disagreeing with its expected sequence.
        do_reset(4);
        repeat (10) tick(0, 1, 0, 0, 0);
        for (int c = 0; c < 10 && cnt_ref != 2; c++) tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 1, 3);
        repeat (12) tick(0, 1, 0, 0, 0);
        repeat (10) tick(0, 1, 1, 0, 0);

        // Counter value beyond the limit.
        do_reset(DEFAULT_LIMIT);
        repeat (5) tick(0, 1, 1, 0, 0);
        tick(0, 1, 1, 1, DEFAULT_LIMIT + 1);
        repeat (1100) tick(0, 1, 1, 0, 0);

        // Reset with events pending at the head.
        do_reset(4);
        for (int c = 0; c < 100 && m_lvl < 3; c++) tick(0, 1, 0, 0, 0);
        tick(1, 0, 1, 0, 0);
        repeat (20) tick(0, 1, 1, 0, 0);

        repeat (10) tick(0, 0, 1, 0, 0);
        chk("sb_leftover", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/wrap_event_monitor.md
# wrap_event_monitor

Downstream consumer of the selector-driven wrap counter (cnt counts 1..limit, reloading 1 when stepped at cnt==limit). Watches the counter's registered outputs and the same step strobe, detects each wrap, measures the cycle gap between wraps, and queues wrap events to a consumer over a valid/ready handshake. An optional shadow model cross-checks the counter against its own specification and raises a sticky error.

## Interface
- DEPTH, 4, event FIFO entries (power of two, ≥2)
- CW, 10, counter/limit width
- GW, 16, gap counter width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- step  in  1  counter step strobe (same signal that drives the counter's selector)
- cnt  in  CW  counter value (registered output of upstream counter)
- limit  in  CW  counter wrap limit (upstream holds 500; treated as static after reset)
- evt_valid  out  1  head of FIFO valid
- evt_ready  in  1  consumer accepts head
- evt_seq  out  8  wrap sequence number of head event
- evt_gap  out  GW  cycles since previous wrap (or since first step) for head event
- wrap_count  out  GW  total wraps detected, saturating
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: event dropped on full FIFO
- err  out  1  sticky: counter check failure (0 when check compiled out)

## Operation
- Reset: FSM IDLE, gap=0, seq=0, wrap_count=0, FIFO empty, evt_valid=0, evt_seq=0, evt_gap=0, level=0, overflow=0, err=0, shadow=0.
- FSM states: IDLE, RUN, ERR (ERR exists only with check enabled).
  - IDLE -> RUN on first cycle with step=1; gap held at 0 in IDLE.
  - RUN: gap increments every cycle, saturating at 2^GW-1.
  - RUN -> ERR on check failure; ERR exits only via rst.
- Wrap detect: wrap = step && (cnt==limit), evaluated in IDLE or RUN.
  - On wrap: push {seq, gap+1}; seq <= seq+1 (mod 256); gap <= 0; wrap_count <= wrap_count+1 saturating.
  - First wrap may occur in the IDLE->RUN cycle (limit==0 upstream edge case: cnt 0 == limit 0); treat identically, gap field = 1.
- FIFO: show-ahead; evt_valid = level!=0; evt_seq/evt_gap reflect head; pop when evt_valid && evt_ready.
  - Push while full with simultaneous pop: both occur, level unchanged, no overflow.
  - Push while full without pop: event dropped, overflow <= 1, seq still increments (consumer sees seq gap).
  - Pop while empty: ignored.
- ERR: no further pushes; queued events still drain; wrap_count frozen; err=1.
- step=0: counter expected to hold; gap still counts in RUN.

## Timing
- Wrap detected combinationally from inputs at edge N; event visible (evt_valid=1, level+1) after edge N; wrap_count updates at edge N.
- Pop at edge N: next head visible after edge N.
- Check failure on inputs at edge N: err=1 and state ERR after edge N.
- rst mid-operation: all state and FIFO contents cleared at that edge, regardless of handshake.

## Configuration
- WRAP_MON_CHECK_EN defined: shadow register mirrors counter: on step, shadow <= (shadow==limit) ? 1 : shadow+1; else hold. Failure when cnt!=shadow or cnt>limit (both checked every non-reset cycle using pre-edge values). Sets err, enters ERR.
- Undefined: no shadow logic, err tied 0, ERR state absent.

## Structure
- Package wrap_mon_pkg: state enum (IDLE, RUN, ERR), CW/GW/seq width defaults, DEFAULT_LIMIT=500, event struct {seq, gap}.
- Sub-module wrap_evt_fifo: parameterised synchronous FIFO (DEPTH, event struct) with push/pop/full/empty/level; top holds FSM, gap/seq/wrap counters, checker.

## Test plan
- limit=4, step constantly 1 from cycle 0 after reset, cnt driven by reference model, evt_ready=1 -> events seq 0,1,2… with gap 5 for first (0->4), then 4 each; wrap_count matches; err=0.
- limit=4, step toggling 1/0, evt_ready=0 -> after 4 wraps level=4, 5th wrap sets overflow=1, level stays 4; draining shows seq 0..3, next event seq 5.
- FIFO full and wrap coincident with evt_ready=1 -> level stays DEPTH, overflow remains 0, new event at tail.
- Check enabled: force cnt=3 when shadow=2 -> err=1 next cycle, further wraps not queued, wrap_count frozen, existing events drain.
- Check enabled: cnt=501 with limit=500 -> err=1; check disabled build: same stimulus -> err=0, events continue.
- Assert rst while level=3 and evt_valid=1 -> next cycle level=0, evt_valid=0, seq=0, overflow=0, state IDLE.
